fb_rect_writer: RTL and testbench
=================================

# fb_rect_writer

Rectangle-fill engine that writes RGB332 pixels into the 640x480 framebuffer, which the video scanout reads back. It accepts one fill command at a time (origin, size, colour), walks the rectangle row by row, and issues one request/acknowledge memory write per pixel. It sits between the game-display logic (segment/background drawing, screen clear) and the framebuffer memory arbiter.

## Interface
Parameters:
- FB_W, 640, framebuffer width in pixels (row pitch in words)
- FB_H, 480, framebuffer height in lines

Ports:
- clk_vid  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- x0  in  10  left column of rectangle
- y0  in  10  top line of rectangle
- w  in  10  width in pixels (0 = no-op)
- h  in  10  height in lines (0 = no-op)
- color  in  8  RGB332 pixel value {R[2:0],G[2:0],B[1:0]}
- busy  out  1  high from command acceptance until done
- done  out  1  one-cycle pulse when command completes
- mem_we  out  1  write request
- mem_addr  out  19  word address = y*FB_W + x
- mem_dout  out  16  write data = {8'h00, color}
- mem_ack  in  1  write accepted this cycle

## Operation
- States: IDLE, SETUP, WRITE, DONE.
- IDLE: busy=0. On start=1, latch x0,y0,w,h,color; go SETUP. start in any other state is ignored.
- SETUP (1 cycle): row_base = y0*FB_W + x0 (19-bit, truncated); col=0, row=0; effective w/h computed (see Configuration). If effective w==0 or h==0 go DONE, else WRITE.
- WRITE: mem_we=1, mem_addr=row_base+col, mem_dout={8'h00,color}. All three held stable until mem_ack.
  - On mem_ack: if col<w-1, col++; else col=0, row_base += FB_W, row++; if that was the last pixel (row==h-1, col==w-1) go DONE.
  - mem_ack while mem_we=0 is ignored.
- DONE (1 cycle): done=1, busy still 1; then IDLE.
- Addition of row_base and FB_W and col wraps modulo 2^19; no multiply after SETUP.
- Reset (asynchronous, any time incl. mid-rectangle): state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_dout=0, counters cleared; the in-flight write is abandoned.

## Timing
- start at cycle N -> busy=1 at N+1 (SETUP), first mem_we at N+2.
- With mem_ack held high: one pixel per cycle; done pulses the cycle after the last ack; total command length = w*h + 2 cycles after start (SETUP + DONE) excluding IDLE.
- Zero-size command: SETUP at N+1, done at N+2, no mem_we.
- busy falls the cycle after done; a new start is accepted the cycle busy is 0.
- All outputs registered.

## Configuration
- FB_RECT_CLIP_EN defined: in SETUP, if x0>=FB_W or y0>=FB_H the command becomes zero-size; else w=min(w,FB_W-x0), h=min(h,FB_H-y0). No write ever lands outside the visible frame.
- Undefined: w,h used as given; addresses beyond the frame (including x overflow into the next row and 19-bit wrap) are written as computed; caller is responsible for bounds.

## Structure
- Shared package fb_pkg: FB_W/FB_H constants, 19-bit address width constant, RGB332 pixel typedef, state enum for this block.
- One natural sub-module: fb_rect_walker (col/row counters and incremental row_base/address generation, advance on ack, last-pixel flag); the top holds the FSM, command latch and memory handshake.

## Test plan
- Fill x0=0,y0=0,w=3,h=2,color=8'hE0, mem_ack always 1 -> addrs 0,1,2,640,641,642 on consecutive cycles, mem_dout=16'h00E0, done 1 cycle after last write.
- Same command with mem_ack high only every 3rd cycle -> addr/data held stable while unacked, identical 6-address sequence, no duplicated or skipped writes.
- w=0,h=5 -> no mem_we; done exactly 2 cycles after start; start asserted during busy ignored.
- With FB_RECT_CLIP_EN: x0=638,y0=479,w=4,h=4 -> exactly writes 307198, 307199; x0=700 -> zero writes, done pulses.
- Without FB_RECT_CLIP_EN: x0=638,y0=0,w=4,h=1 -> addrs 638,639,640,641.
- Assert reset during WRITE of a 10x10 fill -> mem_we,busy,done low immediately; next start of 1x1 at (5,1) writes only addr 645.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer constants, pixel type and rect-writer states
package fb_pkg;
  localparam int FB_W   = 640;
  localparam int FB_H   = 480;
  localparam int ADDR_W = 19;

  typedef logic [7:0] rgb332_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } rect_state_t;
endpackage

// File: rtl/fb_rect_walker.sv
// rtl/fb_rect_walker.sv - col/row walker producing incremental pixel addresses
module fb_rect_walker #(
  parameter int FB_W = fb_pkg::FB_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [fb_pkg::ADDR_W-1:0] base,
  input  logic [9:0]                w_eff,
  input  logic [9:0]                h_eff,
  input  logic                      advance,
  output logic [fb_pkg::ADDR_W-1:0] addr,
  output logic                      last
);
  import fb_pkg::*;

  logic [9:0]        col;
  logic [9:0]        row;
  logic [9:0]        w_q;
  logic [9:0]        h_q;
  logic [ADDR_W-1:0] row_base;

  assign last = (col == w_q - 10'd1) && (row == h_q - 10'd1);

  // addr is kept as its own register so mem_addr leaves the block straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      w_q      <= w_eff;
      h_q      <= h_eff;
      row_base <= base;
      addr     <= base;
    end else if (advance) begin
      if (col < w_q - 10'd1) begin
        col  <= col + 10'd1;
        addr <= addr + 1'b1;
      end else begin
        col      <= '0;
        row      <= row + 10'd1;
        row_base <= row_base + ADDR_W'(FB_W);
        addr     <= row_base + ADDR_W'(FB_W);
      end
    end
  end
endmodule

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - rectangle fill engine writing RGB332 pixels to the framebuffer
// Optional FB_RECT_CLIP_EN clips every command to the visible frame.
module fb_rect_writer #(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [9:0]  w,
  input  logic [9:0]  h,
  input  logic [7:0]  color,
  output logic        busy,
  output logic        done,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic        mem_ack
);
  import fb_pkg::*;

  rect_state_t       state;
  rect_state_t       state_n;
  logic [9:0]        x0_q;
  logic [9:0]        y0_q;
  logic [9:0]        w_q;
  logic [9:0]        h_q;
  rgb332_t           color_q;
  logic [ADDR_W-1:0] base;
  logic [9:0]        w_eff;
  logic [9:0]        h_eff;
  logic              last;
  logic              advance;

  assign base     = ADDR_W'(y0_q) * ADDR_W'(FB_W) + ADDR_W'(x0_q);
  assign advance  = (state == WRITE) && mem_ack;
  assign mem_dout = {8'h00, color_q};

`ifdef FB_RECT_CLIP_EN
  logic [9:0] w_room;
  logic [9:0] h_room;
  assign w_room = 10'(FB_W) - x0_q;
  assign h_room = 10'(FB_H) - y0_q;

  always_comb begin
    w_eff = '0;
    h_eff = '0;
    if (x0_q < 10'(FB_W) && y0_q < 10'(FB_H)) begin
      w_eff = (w_q > w_room) ? w_room : w_q;
      h_eff = (h_q > h_room) ? h_room : h_q;
    end
  end
`else
  assign w_eff = w_q;
  assign h_eff = h_q;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SETUP;
      SETUP:   state_n = (w_eff == '0 || h_eff == '0) ? DONE : WRITE;
      WRITE:   if (mem_ack && last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // status and strobe outputs are registered from the next state
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mem_we  <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else begin
      state  <= state_n;
      busy   <= (state_n != IDLE);
      done   <= (state_n == DONE);
      mem_we <= (state_n == WRITE);
      if (state == IDLE && start) begin
        x0_q    <= x0;
        y0_q    <= y0;
        w_q     <= w;
        h_q     <= h;
        color_q <= color;
      end
    end
  end

  fb_rect_walker #(.FB_W(FB_W)) u_walker (
    .clk     (clk_vid),
    .rst     (reset),
    .load    (state == SETUP),
    .base    (base),
    .w_eff   (w_eff),
    .h_eff   (h_eff),
    .advance (advance),
    .addr    (mem_addr),
    .last    (last)
  );
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb/tb_fb_rect_writer.sv - directed self-checking bench for fb_rect_writer
module tb_fb_rect_writer;
  logic        clk_vid = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [9:0]  x0 = '0, y0 = '0, w = '0, h = '0;
  logic [7:0]  color = '0;
  logic        busy, done, mem_we, mem_ack = 1'b0;
  logic [18:0] mem_addr;
  logic [15:0] mem_dout;

  int checks = 0, passed = 0, fails = 0;
  logic [18:0] wr_q[$];
  logic [18:0] exp_q[$];
  int done_cyc, first_we_cyc, stab_err, dout_err, idle_err;

  always #5 clk_vid = ~clk_vid;

  fb_rect_writer dut (
    .clk_vid(clk_vid), .reset(reset), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .color(color), .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  task automatic tick;
    @(posedge clk_vid);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hDEAD, 32'(exp_q[i]));
  endtask

  // Issue one command, serve the write port with an ack every ack_per cycles,
  // record accepted addresses and cycle offsets (k = cycles after start edge).
  task automatic run_cmd(input logic [9:0] cx, cy, cw, ch, input logic [7:0] cc,
                         input int ack_per, input bit poke);
    logic        pend;
    logic [18:0] paddr;
    pend = 1'b0;
    paddr = '0;
    wr_q.delete();
    done_cyc = -1; first_we_cyc = -1; stab_err = 0; dout_err = 0; idle_err = 0;
    x0 = cx; y0 = cy; w = cw; h = ch; color = cc; start = 1'b1;
    tick;
    start = poke;
    if (poke) begin
      x0 = 10'd3; y0 = 10'd3; w = 10'd7; h = 10'd7; color = 8'h55;
    end
    for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
      if (done) begin
        done_cyc = k;
        start = 1'b0;
      end
      mem_ack = ((k % ack_per) == 0);
      if (mem_we) begin
        if (first_we_cyc < 0) first_we_cyc = k;
        if (pend && mem_addr !== paddr) stab_err++;
        if (mem_dout !== {8'h00, cc}) dout_err++;
        if (mem_ack) begin
          wr_q.push_back(mem_addr);
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          paddr = mem_addr;
        end
      end
      tick;
    end
    start = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) idle_err++;
      tick;
    end
  endtask

  initial begin
    reset = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dout", mem_dout, 0);
    tick; tick;
    reset = 1'b0;
    tick;

    run_cmd(10'd0, 10'd0, 10'd3, 10'd2, 8'hE0, 1, 1'b0);
    exp_q = '{19'd0, 19'd1, 19'd2, 19'd640, 19'd641, 19'd642};
    chk_writes("t1");
    chk("t1_first_we", first_we_cyc, 2);
    chk("t1_done", done_cyc, 8);
    chk("t1_dout", dout_err, 0);
    chk("t1_idle", idle_err, 0);

    run_cmd(10'd0, 10'd0, 10'd3, 10'd2, 8'hE0, 3, 1'b1);
    chk_writes("t2");
    chk("t2_stable", stab_err, 0);
    chk("t2_dout", dout_err, 0);
    chk("t2_first_we", first_we_cyc, 2);
    chk("t2_done", done_cyc, 19);
    chk("t2_idle", idle_err, 0);

    run_cmd(10'd4, 10'd4, 10'd0, 10'd5, 8'h1F, 1, 1'b1);
    exp_q = {};
    chk_writes("t3");
    chk("t3_no_we", first_we_cyc, -1);
    chk("t3_done", done_cyc, 2);
    chk("t3_idle", idle_err, 0);

`ifdef FB_RECT_CLIP_EN
    run_cmd(10'd638, 10'd479, 10'd4, 10'd4, 8'h03, 1, 1'b0);
    exp_q = '{19'd307198, 19'd307199};
    chk_writes("clip_corner");
    chk("clip_corner_done", done_cyc, 4);

    run_cmd(10'd700, 10'd0, 10'd5, 10'd5, 8'h03, 1, 1'b0);
    exp_q = {};
    chk_writes("clip_off");
    chk("clip_off_done", done_cyc, 2);
`else
    run_cmd(10'd638, 10'd0, 10'd4, 10'd1, 8'h92, 1, 1'b0);
    exp_q = '{19'd638, 19'd639, 19'd640, 19'd641};
    chk_writes("noclip_wrap");
    chk("noclip_done", done_cyc, 6);
    chk("noclip_dout", dout_err, 0);
`endif

    x0 = 10'd0; y0 = 10'd0; w = 10'd10; h = 10'd10; color = 8'hFF;
    start = 1'b1;
    mem_ack = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    chk("mid_we", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", mem_addr, 0);
    #2;
    reset = 1'b0;
    mem_ack = 1'b0;
    tick; tick;

    run_cmd(10'd5, 10'd1, 10'd1, 10'd1, 8'h1C, 1, 1'b0);
    exp_q = '{19'd645};
    chk_writes("post_rst");
    chk("post_rst_done", done_cyc, 3);
    chk("post_rst_dout", dout_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
